// File: rtl/sub_bytes_engine.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_engine
// Brief    : Multi-lane handshaked AES SubBytes / InvSubBytes engine.
// Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NCYC  = 16 / LANES;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  // Entry x of each table lives at bits [{~x, 3'b000} +: 8]; entry 0 is the MSB byte.
  localparam logic [2047:0] C_SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] C_SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [127:0]     r_work;
  logic [127:0]     w_work_next;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic [3:0]       w_idx [LANES];
  logic [7:0]       w_sub [LANES];

  assign w_last = (r_cnt == CNT_W'(NCYC - 1));

  // Lane l works on byte r_cnt*LANES + l; both ROMs are read and the latched mode picks one.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] w_byte;
    logic [7:0] w_fwd;
    logic [7:0] w_inv;
    assign w_idx[l]  = 4'(int'(r_cnt) * LANES + l);
    assign w_byte    = r_work[{w_idx[l], 3'b000} +: 8];
    assign w_fwd     = C_SBOX_FWD[{~w_byte, 3'b000} +: 8];
    assign w_inv     = C_SBOX_INV[{~w_byte, 3'b000} +: 8];
    assign w_sub[l]  = r_mode ? w_inv : w_fwd;
  end

  always_comb begin
    w_work_next = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_next[{w_idx[l], 3'b000} +: 8] = w_sub[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake outputs decode the state register only, so no input-to-output paths exist.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = ST_PROC;
        end
      end
      ST_PROC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work <= in_data;
            r_mode <= in_inv;
            r_cnt  <= '0;
          end
        end
        ST_PROC: begin
          r_work <= w_work_next;
          r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = r_work;

endmodule
`default_nettype wire
